// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter for a single register-file write/clear port.
// While idle, rf_addr walks the register file for the display scan.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no owner; rf_addr follows the scan counter; a request moves to GRANT
// GRANT   | one-cycle gnt plus rf_load or rf_clr for the latched winner
// RELEASE | waits for the winner to drop req, then returns to IDLE
module regfile_arbiter #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 3,
   parameter int SCAN_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  op0,
   input  logic                  op1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] din1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rf_load,
   output logic                  rf_clr,
   output logic [ADDR_WIDTH-1:0] rf_addr,
   output logic [DATA_WIDTH-1:0] rf_din,
   output logic                  busy
);

   localparam int DIV_W = (SCAN_DIV > 0) ? SCAN_DIV : 1;
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'((1 << SCAN_DIV) - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t                  state_q;
   logic                    gnt0_q;
   logic                    gnt1_q;
   logic                    rf_load_q;
   logic                    rf_clr_q;
   logic [ADDR_WIDTH-1:0]   rf_addr_q;
   logic [DATA_WIDTH-1:0]   rf_din_q;
   logic                    busy_q;
   logic                    last_q;
   logic                    win_q;

   logic [ADDR_WIDTH-1:0]   scan_q;
   logic [ADDR_WIDTH-1:0]   scan_d;
   logic [DIV_W-1:0]        div_q;
   logic [DIV_W-1:0]        div_d;

   logic                    scan_tick;
   logic                    pick1;
   logic                    win_op;
   logic [ADDR_WIDTH-1:0]   win_addr;
   logic [DATA_WIDTH-1:0]   win_din;
   logic                    owner_req_low;

   // Scan only advances on edges that leave the block idle, so a transaction
   // freezes both the address and the divider phase.
   always_comb begin
      scan_tick     = (state_q == IDLE) && !req0 && !req1;
      scan_d        = scan_q;
      div_d         = div_q;
      if (scan_tick) begin
         if (div_q == '0) begin
            div_d  = DIV_RELOAD;
            scan_d = scan_q + ADDR_WIDTH'(1);
         end else begin
            div_d  = div_q - DIV_W'(1);
         end
      end
      pick1         = req1 && (!req0 || !last_q);
      win_op        = pick1 ? op1 : op0;
      win_addr      = pick1 ? addr1 : addr0;
      win_din       = pick1 ? din1 : din0;
      owner_req_low = win_q ? !req1 : !req0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_q <= '0;
         div_q  <= DIV_RELOAD;
      end else begin
         scan_q <= scan_d;
         div_q  <= div_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rf_load_q <= 1'b0;
         rf_clr_q  <= 1'b0;
         rf_addr_q <= '0;
         rf_din_q  <= '0;
         busy_q    <= 1'b0;
         last_q    <= 1'b1;
         win_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  state_q   <= GRANT;
                  busy_q    <= 1'b1;
                  win_q     <= pick1;
                  last_q    <= pick1;
                  gnt0_q    <= !pick1;
                  gnt1_q    <= pick1;
                  rf_load_q <= !win_op;
                  rf_clr_q  <= win_op;
                  rf_addr_q <= win_addr;
                  rf_din_q  <= win_din;
               end else begin
                  rf_addr_q <= scan_d;
               end
            end
            GRANT: begin
               state_q   <= RELEASE;
               gnt0_q    <= 1'b0;
               gnt1_q    <= 1'b0;
               rf_load_q <= 1'b0;
               rf_clr_q  <= 1'b0;
            end
            RELEASE: begin
               if (owner_req_low) begin
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  rf_addr_q <= scan_q;
               end
            end
            default: begin
               state_q   <= IDLE;
               gnt0_q    <= 1'b0;
               gnt1_q    <= 1'b0;
               rf_load_q <= 1'b0;
               rf_clr_q  <= 1'b0;
               busy_q    <= 1'b0;
               rf_addr_q <= scan_q;
            end
         endcase
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign rf_load = rf_load_q;
   assign rf_clr  = rf_clr_q;
   assign rf_addr = rf_addr_q;
   assign rf_din  = rf_din_q;
   assign busy    = busy_q;

endmodule
